// File: rtl/enemy_pkg.sv
`default_nettype none
// ============================================================================
// Module   : enemy_pkg
// Purpose  : Shared formation state encoding, coordinate width and packed-bus
//            slot helper used by the enemy and bullet blocks.
// Revision : 1.0 - initial release
// ============================================================================
package enemy_pkg;

  localparam int COORD_W = 10;

  typedef enum logic [1:0] {
    PLAY       = 2'd0,
    CLEAR_WAIT = 2'd1,
    RESPAWN    = 2'd2
  } formation_state_e;

  // Bit offset of slot idx inside a packed coordinate bus.
  function automatic int coord_lsb(input int idx);
    return idx * COORD_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/enemy_formation_controller_hit_matrix.sv
`default_nettype none
// ============================================================================
// Module   : enemy_hit_matrix
// Purpose  : Combinational enemy x bullet overlap test with priority
//            resolution into a kill mask and a consumed-bullet mask.
// Revision : 1.0 - initial release
// ============================================================================
module enemy_hit_matrix
  import enemy_pkg::*;
#(
  parameter int ENEMY_COUNT  = 8,
  parameter int BULLET_COUNT = 8,
  parameter int ENEMY_SIZE   = 32
) (
  input  logic [ENEMY_COUNT*COORD_W-1:0]  enemy_x,
  input  logic [ENEMY_COUNT*COORD_W-1:0]  enemy_y,
  input  logic [ENEMY_COUNT-1:0]          enemy_alive,
  input  logic [BULLET_COUNT*COORD_W-1:0] bullet_x,
  input  logic [BULLET_COUNT*COORD_W-1:0] bullet_y,
  input  logic [BULLET_COUNT-1:0]         bullet_active,
  output logic [ENEMY_COUNT-1:0]          kill_mask,
  output logic [BULLET_COUNT-1:0]         consumed_mask
);

  localparam int               EXT_W    = COORD_W + 1;
  localparam logic [EXT_W-1:0] SIZE_EXT = EXT_W'(ENEMY_SIZE);

  logic [EXT_W-1:0]       bx, by, ex, ey;
  logic [ENEMY_COUNT-1:0] overlap, first_hit, claim;

  always_comb begin
    kill_mask     = '0;
    consumed_mask = '0;
    bx            = '0;
    by            = '0;
    ex            = '0;
    ey            = '0;
    overlap       = '0;
    first_hit     = '0;
    claim         = '0;
    for (int j = 0; j < BULLET_COUNT; j++) begin
      bx      = {1'b0, bullet_x[coord_lsb(j) +: COORD_W]};
      by      = {1'b0, bullet_y[coord_lsb(j) +: COORD_W]};
      overlap = '0;
      for (int i = 0; i < ENEMY_COUNT; i++) begin
        ex         = {1'b0, enemy_x[coord_lsb(i) +: COORD_W]};
        ey         = {1'b0, enemy_y[coord_lsb(i) +: COORD_W]};
        overlap[i] = bullet_active[j] && enemy_alive[i]
                  && (bx >= ex) && (bx < ex + SIZE_EXT)
                  && (by >= ey) && (by < ey + SIZE_EXT);
      end
      // A bullet targets only its lowest-index enemy; if a lower bullet
      // already claimed that enemy, this one passes through unconsumed.
      first_hit        = overlap & (~overlap + ENEMY_COUNT'(1));
      claim            = first_hit & ~kill_mask;
      consumed_mask[j] = |claim;
      kill_mask        = kill_mask | claim;
    end
  end

endmodule
`default_nettype wire

// File: rtl/enemy_formation_controller.sv
`default_nettype none
// ============================================================================
// Module   : enemy_formation_controller
// Purpose  : Moves a row of enemies as one formation, resolves bullet hits,
//            counts kills and waves, and respawns the row after a clear.
// Revision : 1.0 - initial release
// ============================================================================
module enemy_formation_controller
  import enemy_pkg::*;
#(
  parameter int ENEMY_COUNT   = 8,
  parameter int BULLET_COUNT  = 8,
  parameter int ENEMY_SIZE    = 32,
  parameter int SCREEN_W      = 640,
  parameter int BREACH_Y      = 448,
  parameter int BASE_X        = 32,
  parameter int BASE_Y        = 64,
  parameter int SPACING       = 64,
  parameter int MOVE_DIV      = 524288,
  parameter int STEP_X        = 2,
  parameter int STEP_DOWN     = 16,
  parameter int MAX_STEP      = 8,
  parameter int RESPAWN_TICKS = 64
) (
  input  logic                            clk25,
  input  logic                            reset,
  input  logic                            revive,
  input  logic [BULLET_COUNT*COORD_W-1:0] bullet_x,
  input  logic [BULLET_COUNT*COORD_W-1:0] bullet_y,
  input  logic [BULLET_COUNT-1:0]         bullet_active,
  output logic [BULLET_COUNT-1:0]         bullet_hit,
  output logic [ENEMY_COUNT*COORD_W-1:0]  enemy_x,
  output logic [ENEMY_COUNT*COORD_W-1:0]  enemy_y,
  output logic [ENEMY_COUNT-1:0]          enemy_alive,
  output logic [15:0]                     kill_count,
  output logic [3:0]                      wave,
  output logic                            wave_clear,
  output logic                            breach
);

  localparam int PRE_W  = $clog2(MOVE_DIV);
  localparam int WAIT_W = $clog2(RESPAWN_TICKS + 1);
  localparam int ENV_W  = COORD_W + 2;

  formation_state_e          state_q, state_d;
  logic [COORD_W-1:0]        off_x_q, off_x_d, off_y_q, off_y_d;
  logic                      dir_left_q, dir_left_d;
  logic [ENEMY_COUNT-1:0]    alive_q, alive_d;
  logic [PRE_W-1:0]          prescaler_q, prescaler_d;
  logic [WAIT_W-1:0]         wait_cnt_q, wait_cnt_d;
  logic [BULLET_COUNT-1:0]   hit_q, hit_d;
  logic [15:0]               kill_q, kill_d;
  logic [3:0]                wave_q, wave_d;
  logic                      wave_clear_q, wave_clear_d;
  logic                      breach_q, breach_d;

  logic                      tick;
  logic [COORD_W-1:0]        pos_x [ENEMY_COUNT];
  logic [COORD_W-1:0]        pos_y;
  logic [COORD_W-1:0]        left_x, right_x, step_sum, step, down_y;
  logic                      hit_right, bounce, past_breach;
  logic [ENEMY_COUNT-1:0]    kill_mask;
  logic [BULLET_COUNT-1:0]   consumed_mask;
  logic [4:0]                kill_num;
  logic [16:0]               kill_sum;

  assign pos_y = COORD_W'(BASE_Y) + off_y_q;

  for (genvar gi = 0; gi < ENEMY_COUNT; gi++) begin : g_pos
    assign pos_x[gi] = COORD_W'(BASE_X + gi * SPACING) + off_x_q;
    assign enemy_x[coord_lsb(gi) +: COORD_W] = pos_x[gi];
    assign enemy_y[coord_lsb(gi) +: COORD_W] = pos_y;
  end

  enemy_hit_matrix #(
    .ENEMY_COUNT  (ENEMY_COUNT),
    .BULLET_COUNT (BULLET_COUNT),
    .ENEMY_SIZE   (ENEMY_SIZE)
  ) u_hit_matrix (
    .enemy_x       (enemy_x),
    .enemy_y       (enemy_y),
    .enemy_alive   (alive_q),
    .bullet_x      (bullet_x),
    .bullet_y      (bullet_y),
    .bullet_active (bullet_active),
    .kill_mask     (kill_mask),
    .consumed_mask (consumed_mask)
  );

  assign tick        = (prescaler_q == PRE_W'(MOVE_DIV - 1));
  assign prescaler_d = tick ? '0 : prescaler_q + PRE_W'(1);

  // Extent comes from the registered mask, so a same-cycle hit cannot
  // shift the edge used for this tick's bounce decision.
  always_comb begin
    left_x  = '0;
    right_x = '0;
    for (int i = ENEMY_COUNT - 1; i >= 0; i--)
      if (alive_q[i]) left_x = pos_x[i];
    for (int i = 0; i < ENEMY_COUNT; i++)
      if (alive_q[i]) right_x = pos_x[i];
  end

  assign step_sum    = COORD_W'(STEP_X) + COORD_W'(wave_q);
  assign step        = (step_sum > COORD_W'(MAX_STEP)) ? COORD_W'(MAX_STEP) : step_sum;
  assign hit_right   = ({2'b00, right_x} + ENV_W'(ENEMY_SIZE) + {2'b00, step}) > ENV_W'(SCREEN_W);
  assign bounce      = dir_left_q ? (left_x < step) : hit_right;
  assign down_y      = off_y_q + COORD_W'(STEP_DOWN);
  assign past_breach = (ENV_W'(BASE_Y) + {2'b00, down_y} + ENV_W'(ENEMY_SIZE)) > ENV_W'(BREACH_Y);

  always_comb begin
    kill_num = '0;
    for (int i = 0; i < ENEMY_COUNT; i++)
      kill_num = kill_num + 5'(kill_mask[i]);
  end

  assign kill_sum = {1'b0, kill_q} + 17'(kill_num);

  always_comb begin
    state_d      = state_q;
    off_x_d      = off_x_q;
    off_y_d      = off_y_q;
    dir_left_d   = dir_left_q;
    alive_d      = alive_q;
    wait_cnt_d   = wait_cnt_q;
    hit_d        = '0;
    kill_d       = kill_q;
    wave_d       = wave_q;
    wave_clear_d = 1'b0;
    breach_d     = 1'b0;
    case (state_q)
      PLAY: begin
        if (tick) begin
          if (bounce) begin
            dir_left_d = ~dir_left_q;
            if (past_breach) begin
              off_y_d  = '0;
              breach_d = 1'b1;
            end else begin
              off_y_d  = down_y;
            end
          end else if (dir_left_q) begin
            off_x_d = off_x_q - step;
          end else begin
            off_x_d = off_x_q + step;
          end
        end
        if (revive) begin
          alive_d = '1;
        end else begin
          alive_d = alive_q & ~kill_mask;
          hit_d   = consumed_mask;
          kill_d  = kill_sum[16] ? 16'hFFFF : kill_sum[15:0];
          if ((|kill_mask) && (alive_d == '0)) begin
            wave_clear_d = 1'b1;
            wait_cnt_d   = '0;
            state_d      = CLEAR_WAIT;
          end
        end
      end
      CLEAR_WAIT: begin
        if (revive) begin
          state_d = RESPAWN;
        end else if (tick) begin
          if (wait_cnt_q == WAIT_W'(RESPAWN_TICKS - 1)) state_d = RESPAWN;
          else wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      RESPAWN: begin
        alive_d    = '1;
        off_x_d    = '0;
        off_y_d    = '0;
        dir_left_d = 1'b0;
        wave_d     = (wave_q == 4'hF) ? wave_q : wave_q + 4'd1;
        state_d    = PLAY;
      end
      default: state_d = PLAY;
    endcase
  end

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      state_q      <= PLAY;
      off_x_q      <= '0;
      off_y_q      <= '0;
      dir_left_q   <= 1'b0;
      alive_q      <= '1;
      prescaler_q  <= '0;
      wait_cnt_q   <= '0;
      hit_q        <= '0;
      kill_q       <= '0;
      wave_q       <= '0;
      wave_clear_q <= 1'b0;
      breach_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      off_x_q      <= off_x_d;
      off_y_q      <= off_y_d;
      dir_left_q   <= dir_left_d;
      alive_q      <= alive_d;
      prescaler_q  <= prescaler_d;
      wait_cnt_q   <= wait_cnt_d;
      hit_q        <= hit_d;
      kill_q       <= kill_d;
      wave_q       <= wave_d;
      wave_clear_q <= wave_clear_d;
      breach_q     <= breach_d;
    end
  end

  assign bullet_hit  = hit_q;
  assign enemy_alive = alive_q;
  assign kill_count  = kill_q;
  assign wave        = wave_q;
  assign wave_clear  = wave_clear_q;
  assign breach      = breach_q;

endmodule
`default_nettype wire

// File: tb/tb_enemy_formation_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_enemy_formation_controller
// Purpose  : Directed self-checking bench for enemy_formation_controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_enemy_formation_controller;

  logic        clk25;
  logic        reset;
  logic        revive;
  logic [79:0] bullet_x;
  logic [79:0] bullet_y;
  logic [7:0]  bullet_active;
  logic [7:0]  bullet_hit;
  logic [79:0] enemy_x;
  logic [79:0] enemy_y;
  logic [7:0]  enemy_alive;
  logic [15:0] kill_count;
  logic [3:0]  wave;
  logic        wave_clear;
  logic        breach;

  int          checks = 0;
  int          errors = 0;
  int          n;
  logic [9:0]  prev_y;

  enemy_formation_controller #(
    .MOVE_DIV (4)
  ) dut (
    .clk25         (clk25),
    .reset         (reset),
    .revive        (revive),
    .bullet_x      (bullet_x),
    .bullet_y      (bullet_y),
    .bullet_active (bullet_active),
    .bullet_hit    (bullet_hit),
    .enemy_x       (enemy_x),
    .enemy_y       (enemy_y),
    .enemy_alive   (enemy_alive),
    .kill_count    (kill_count),
    .wave          (wave),
    .wave_clear    (wave_clear),
    .breach        (breach)
  );

  initial clk25 = 1'b0;
  always #5 clk25 = ~clk25;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk25);
    @(negedge clk25);
  endtask

  function automatic logic [9:0] ex_at(input int i);
    return enemy_x[i*10 +: 10];
  endfunction

  function automatic logic [9:0] ey_at(input int i);
    return enemy_y[i*10 +: 10];
  endfunction

  task automatic aim(input int j, input logic [9:0] x, input logic [9:0] y);
    bullet_x[j*10 +: 10] = x;
    bullet_y[j*10 +: 10] = y;
    bullet_active[j]     = 1'b1;
  endtask

  task automatic clear_bullets();
    bullet_x      = '0;
    bullet_y      = '0;
    bullet_active = '0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_x0"},    ex_at(0),    32);
    check({tag, "_x7"},    ex_at(7),    480);
    check({tag, "_y0"},    ey_at(0),    64);
    check({tag, "_alive"}, enemy_alive, 8'hFF);
    check({tag, "_hit"},   bullet_hit,  0);
    check({tag, "_kills"}, kill_count,  0);
    check({tag, "_wave"},  wave,        0);
    check({tag, "_clear"}, wave_clear,  0);
    check({tag, "_breach"}, breach,     0);
  endtask

  initial begin
    reset  = 1'b1;
    revive = 1'b0;
    clear_bullets();
    repeat (2) @(negedge clk25);
    check_reset_values("rst");

    // First tick lands on the 4th edge after release.
    reset = 1'b0;
    repeat (3) cycle();
    check("pre_tick_x0", ex_at(0), 32);
    cycle();
    check("tick1_x0", ex_at(0), 34);

    aim(0, 10'd40, 10'd90);
    cycle();
    clear_bullets();
    check("hit0_alive", enemy_alive, 8'hFE);
    check("hit0_pulse", bullet_hit, 8'h01);
    check("hit0_kills", kill_count, 1);

    bullet_x[10 +: 10] = 10'd170;
    bullet_y[10 +: 10] = 10'd80;
    cycle();
    clear_bullets();
    check("inactive_alive", enemy_alive, 8'hFE);
    check("hit_pulse_end", bullet_hit, 8'h00);

    aim(0, 10'd110, 10'd80);
    aim(3, 10'd110, 10'd80);
    cycle();
    clear_bullets();
    check("dual_alive", enemy_alive, 8'hFC);
    check("dual_hit", bullet_hit, 8'h01);
    check("dual_kills", kill_count, 2);

    aim(5, 10'd490, 10'd80);
    cycle();
    clear_bullets();
    check("e7_alive", enemy_alive, 8'h7C);
    check("e7_hit", bullet_hit, 8'h20);
    check("e7_kills", kill_count, 3);
    check("tick2_x0", ex_at(0), 36);

    // Enemy 6 is now rightmost: bounce with off_x = 192 (x6 = 608).
    n = 0;
    while (ey_at(0) == 10'd64 && n < 1000) begin
      cycle();
      n++;
    end
    check("bounce_y", ey_at(0), 80);
    check("bounce_x6", ex_at(6), 608);
    check("bounce_x0", ex_at(0), 224);
    repeat (4) cycle();
    check("left_step_x0", ex_at(0), 222);

    // 23rd bounce (a right-edge one) would put the row past the breach line.
    n = 0;
    prev_y = ey_at(0);
    while (breach !== 1'b1 && n < 20000) begin
      prev_y = ey_at(0);
      cycle();
      n++;
    end
    check("breach_pulse", breach, 1);
    check("breach_prev_y", prev_y, 416);
    check("breach_wrap_y", ey_at(0), 64);
    check("breach_x0", ex_at(0), 224);
    cycle();
    check("breach_one_cycle", breach, 0);

    for (int i = 2; i <= 6; i++) aim(i, ex_at(i) + 10'd16, ey_at(i) + 10'd16);
    cycle();
    clear_bullets();
    check("clear_pulse", wave_clear, 1);
    check("clear_alive", enemy_alive, 8'h00);
    check("clear_hit", bullet_hit, 8'h7C);
    check("clear_kills", kill_count, 8);
    cycle();
    n = 1;
    check("clear_pulse_end", wave_clear, 0);
    check("clear_hit_end", bullet_hit, 8'h00);
    while (enemy_alive !== 8'hFF && n < 400) begin
      cycle();
      n++;
      if (n == 100) begin
        check("frozen_x0", ex_at(0), 224);
        check("frozen_y0", ey_at(0), 64);
      end
    end
    check("respawn_delay_ok", (n >= 254 && n <= 257), 1);
    check("respawn_alive", enemy_alive, 8'hFF);
    check("respawn_x0", ex_at(0), 32);
    check("respawn_y0", ey_at(0), 64);
    check("respawn_wave", wave, 1);
    check("respawn_kills", kill_count, 8);
    n = 0;
    while (ex_at(0) == 10'd32 && n < 10) begin
      cycle();
      n++;
    end
    check("wave1_step_x0", ex_at(0), 35);

    aim(0, ex_at(0) + 10'd16, ey_at(0) + 10'd16);
    cycle();
    clear_bullets();
    check("w1_hit_alive", enemy_alive, 8'hFE);
    check("w1_hit_kills", kill_count, 9);
    revive = 1'b1;
    aim(1, ex_at(2) + 10'd16, ey_at(2) + 10'd16);
    cycle();
    revive = 1'b0;
    clear_bullets();
    check("revive_alive", enemy_alive, 8'hFF);
    check("revive_hit", bullet_hit, 8'h00);
    check("revive_kills", kill_count, 9);

    for (int i = 0; i < 8; i++) aim(i, ex_at(i) + 10'd16, ey_at(i) + 10'd16);
    cycle();
    clear_bullets();
    check("clear2_pulse", wave_clear, 1);
    check("clear2_kills", kill_count, 17);
    revive = 1'b1;
    cycle();
    revive = 1'b0;
    check("cw_revive_wait", enemy_alive, 8'h00);
    cycle();
    check("cw_revive_alive", enemy_alive, 8'hFF);
    check("cw_revive_wave", wave, 2);
    check("cw_revive_x0", ex_at(0), 32);

    for (int i = 0; i < 8; i++) aim(i, ex_at(i) + 10'd16, ey_at(i) + 10'd16);
    cycle();
    clear_bullets();
    check("clear3_kills", kill_count, 25);
    repeat (5) cycle();
    reset = 1'b1;
    #1;
    check_reset_values("midrst");
    @(negedge clk25);
    reset = 1'b0;
    repeat (3) cycle();
    check("rst2_pre_tick_x0", ex_at(0), 32);
    cycle();
    check("rst2_tick_x0", ex_at(0), 34);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
